// File: rtl/matrix_read_pkg.sv
// Shared state encoding and width/latency constants for the matrix read sequencer.
package matrix_read_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int DEF_ADDR_W  = 16;
  localparam int DEF_DATA_W  = 16;
  localparam int DEF_DIM_W   = 8;
  localparam int MAX_RAM_LAT = 3;

  // Output FIFO must hold every read that can be in flight plus one, so the
  // RAM pipe can stream while the head element waits for out_ready.
  function automatic int fifo_depth(input int ram_lat);
    return ((ram_lat > MAX_RAM_LAT) ? MAX_RAM_LAT : ram_lat) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_small.sv
// Small register FIFO with occupancy count; push when full and pop when empty are ignored.
// Zero-latency read port: pop_dat_o shows the head entry while empty_o is low.
module sync_fifo_small #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push_i,
  input  logic [WIDTH-1:0]             push_dat_i,
  input  logic                         pop_i,
  output logic [WIDTH-1:0]             pop_dat_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign pop_dat_o = mem_q[rd_ptr_q];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
  end

endmodule

// File: rtl/matrix_read_sequencer.sv
// Walks a rows x cols operand-RAM window (column-major with MATRIX_READ_COLMAJOR_EN) and streams it out;
// first out_valid RAM_LAT+2 cycles after start, reads throttled by FIFO credit so backpressure never drops data.
module matrix_read_sequencer
  import matrix_read_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int DIM_W   = DEF_DIM_W,
  parameter int RAM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [DIM_W-1:0]  rows_i,
  input  logic [DIM_W-1:0]  cols_i,
  input  logic [ADDR_W-1:0] row_stride_i,
`ifdef MATRIX_READ_COLMAJOR_EN
  input  logic              col_major_i,
`endif
  output logic              busy_o,
  output logic              done_o,
  output logic              ram_rd_en_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  input  logic [DATA_W-1:0] ram_rdata_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic              out_last_o
);

  localparam int DEPTH = fifo_depth(RAM_LAT);
  localparam int CNT_W = $clog2(DEPTH + 1);

  state_e             state_q, state_d;
  logic [DIM_W-1:0]   rows_q, cols_q, inner_cnt_q, outer_cnt_q, inner_lim, outer_lim;
  logic [ADDR_W-1:0]  stride_q, line_base_q, addr_q, inner_step, outer_step;
  logic [RAM_LAT-1:0] vld_sr_q, last_sr_q;
  logic               issue, issue_ok, inner_wrap, last_elem, pop;
  logic               fifo_empty, fifo_full;
  logic [CNT_W-1:0]   fifo_cnt;
  logic [CNT_W:0]     credit_use;
  logic [DATA_W:0]    fifo_dout;

`ifdef MATRIX_READ_COLMAJOR_EN
  logic col_major_q;
  assign inner_lim  = col_major_q ? rows_q : cols_q;
  assign outer_lim  = col_major_q ? cols_q : rows_q;
  assign inner_step = col_major_q ? stride_q : ADDR_W'(1);
  assign outer_step = col_major_q ? ADDR_W'(1) : stride_q;
`else
  assign inner_lim  = cols_q;
  assign outer_lim  = rows_q;
  assign inner_step = ADDR_W'(1);
  assign outer_step = stride_q;
`endif

  assign inner_wrap = (inner_cnt_q == inner_lim - 1'b1);
  assign last_elem  = inner_wrap && (outer_cnt_q == outer_lim - 1'b1);

  // Occupancy plus in-flight reads, net of this cycle's pop, stays within DEPTH,
  // which lets the stream run one element per cycle with out_ready held high.
  assign credit_use = {1'b0, fifo_cnt} + (CNT_W+1)'($countones(vld_sr_q)) - {{CNT_W{1'b0}}, pop};
  assign issue_ok   = !fifo_full && (credit_use < (CNT_W+1)'(DEPTH));

  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) state_d = (rows_i == '0 || cols_i == '0) ? ST_DONE : ST_ISSUE;
      end
      ST_ISSUE: begin
        if (issue_ok) begin
          issue = 1'b1;
          if (last_elem) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (fifo_empty && vld_sr_q == '0) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rows_q      <= '0;
      cols_q      <= '0;
      stride_q    <= '0;
      line_base_q <= '0;
      addr_q      <= '0;
      inner_cnt_q <= '0;
      outer_cnt_q <= '0;
`ifdef MATRIX_READ_COLMAJOR_EN
      col_major_q <= 1'b0;
`endif
    end else if (state_q == ST_IDLE && start_i) begin
      rows_q      <= rows_i;
      cols_q      <= cols_i;
      stride_q    <= row_stride_i;
      line_base_q <= base_addr_i;
      addr_q      <= base_addr_i;
      inner_cnt_q <= '0;
      outer_cnt_q <= '0;
`ifdef MATRIX_READ_COLMAJOR_EN
      col_major_q <= col_major_i;
`endif
    end else if (issue) begin
      if (inner_wrap) begin
        inner_cnt_q <= '0;
        outer_cnt_q <= outer_cnt_q + 1'b1;
        line_base_q <= line_base_q + outer_step;
        addr_q      <= line_base_q + outer_step;
      end else begin
        inner_cnt_q <= inner_cnt_q + 1'b1;
        addr_q      <= addr_q + inner_step;
      end
    end
  end

  // Valid/last tags travel alongside each read so returning data is pushed on the right cycle.
  if (RAM_LAT == 1) begin : g_sr1
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        vld_sr_q  <= '0;
        last_sr_q <= '0;
      end else begin
        vld_sr_q  <= issue;
        last_sr_q <= last_elem;
      end
    end
  end else begin : g_srn
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        vld_sr_q  <= '0;
        last_sr_q <= '0;
      end else begin
        vld_sr_q  <= {vld_sr_q[RAM_LAT-2:0], issue};
        last_sr_q <= {last_sr_q[RAM_LAT-2:0], last_elem};
      end
    end
  end

  sync_fifo_small #(
    .DEPTH(DEPTH),
    .WIDTH(DATA_W + 1)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_i    (vld_sr_q[RAM_LAT-1]),
    .push_dat_i({last_sr_q[RAM_LAT-1], ram_rdata_i}),
    .pop_i     (pop),
    .pop_dat_o (fifo_dout),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (fifo_cnt)
  );

  assign busy_o      = (state_q != ST_IDLE);
  assign done_o      = (state_q == ST_DONE);
  assign ram_rd_en_o = issue;
  assign ram_addr_o  = addr_q;
  assign out_valid_o = !fifo_empty;
  assign pop         = out_valid_o && out_ready_i;
  assign out_data_o  = out_valid_o ? fifo_dout[DATA_W-1:0] : '0;
  assign out_last_o  = out_valid_o && fifo_dout[DATA_W];

endmodule

// File: tb/tb_matrix_read_sequencer.sv
// Directed bench for matrix_read_sequencer with a behavioural fixed-latency RAM.
module tb_matrix_read_sequencer;

  localparam int AW  = 16;
  localparam int DW  = 16;
  localparam int DMW = 8;
  localparam int LAT = 1;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           start_i = 1'b0;
  logic [AW-1:0]  base_addr_i = '0;
  logic [DMW-1:0] rows_i = '0;
  logic [DMW-1:0] cols_i = '0;
  logic [AW-1:0]  row_stride_i = '0;
`ifdef MATRIX_READ_COLMAJOR_EN
  logic           col_major_i = 1'b0;
`endif
  logic           busy_o, done_o, ram_rd_en_o, out_valid_o, out_last_o;
  logic           out_ready_i = 1'b1;
  logic [AW-1:0]  ram_addr_o;
  logic [DW-1:0]  ram_rdata_i, out_data_o;

  always #5 clk = ~clk;

  matrix_read_sequencer #(
    .ADDR_W(AW), .DATA_W(DW), .DIM_W(DMW), .RAM_LAT(LAT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .base_addr_i (base_addr_i),
    .rows_i      (rows_i),
    .cols_i      (cols_i),
    .row_stride_i(row_stride_i),
`ifdef MATRIX_READ_COLMAJOR_EN
    .col_major_i (col_major_i),
`endif
    .busy_o      (busy_o),
    .done_o      (done_o),
    .ram_rd_en_o (ram_rd_en_o),
    .ram_addr_o  (ram_addr_o),
    .ram_rdata_i (ram_rdata_i),
    .out_data_o  (out_data_o),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_last_o  (out_last_o)
  );

  function automatic logic [DW-1:0] ram_val(input logic [AW-1:0] a);
    return {a[7:0], a[15:8]} ^ 16'h3C5A;
  endfunction

  logic [DW-1:0] rpipe [LAT];
  always @(posedge clk) begin
    rpipe[0] <= ram_rd_en_o ? ram_val(ram_addr_o) : 16'hDEAD;
    for (int i = 1; i < LAT; i++) rpipe[i] <= rpipe[i-1];
  end
  assign ram_rdata_i = rpipe[LAT-1];

  logic [AW-1:0] addr_log [$];
  logic [DW-1:0] data_log [$];
  logic          last_log [$];
  int done_cnt, vld_cnt, iss_tot, pop_tot, max_out;

  always @(negedge clk) begin
    if (iss_tot - pop_tot > max_out) max_out = iss_tot - pop_tot;
    if (ram_rd_en_o) begin
      addr_log.push_back(ram_addr_o);
      iss_tot++;
    end
    if (out_valid_o && out_ready_i) begin
      data_log.push_back(out_data_o);
      last_log.push_back(out_last_o);
      pop_tot++;
    end
    if (out_valid_o) vld_cnt++;
    if (done_o) done_cnt++;
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    addr_log.delete();
    data_log.delete();
    last_log.delete();
    done_cnt = 0; vld_cnt = 0; iss_tot = 0; pop_tot = 0; max_out = 0;
  endtask

  task automatic do_start(input logic [AW-1:0] base, input logic [DMW-1:0] r,
                          input logic [DMW-1:0] c, input logic [AW-1:0] stride);
    base_addr_i = base; rows_i = r; cols_i = c; row_stride_i = stride;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget, input logic [3:0] pat);
    int n = 0;
    while (done_o !== 1'b1 && n < budget) begin
      out_ready_i = pat[n % 4];
      tick();
      n++;
    end
    chk(tag, (n < budget) ? 32'd1 : 32'd0, 32'd1);
    out_ready_i = 1'b1;
    tick();
  endtask

  task automatic check_stream(input string tag, input logic [AW-1:0] exp_addr [$]);
    chk({tag, "_addr_count"}, addr_log.size(), exp_addr.size());
    chk({tag, "_data_count"}, data_log.size(), exp_addr.size());
    for (int i = 0; i < exp_addr.size(); i++) begin
      chk({tag, "_addr"}, (i < addr_log.size()) ? addr_log[i] : 16'hXXXX, exp_addr[i]);
      chk({tag, "_data"}, (i < data_log.size()) ? data_log[i] : 16'hXXXX, ram_val(exp_addr[i]));
      chk({tag, "_last"}, (i < last_log.size()) ? last_log[i] : 1'bx, (i == exp_addr.size() - 1));
    end
    chk({tag, "_done_once"}, done_cnt, 1);
    chk({tag, "_idle_after"}, busy_o, 0);
  endtask

  logic [AW-1:0] exp_q [$];

  initial begin
    clear_logs();
    #1;
    chk("reset_busy", busy_o, 0);
    chk("reset_done", done_o, 0);
    chk("reset_rd_en", ram_rd_en_o, 0);
    chk("reset_addr", ram_addr_o, 0);
    chk("reset_valid", out_valid_o, 0);
    chk("reset_data", out_data_o, 0);
    chk("reset_last", out_last_o, 0);
    tick(); tick();
    rst = 1'b1;
    tick();

    // 2x3 row-major, first valid RAM_LAT+2 cycles after start
    clear_logs();
    do_start(16'h0010, 8'd2, 8'd3, 16'h0008);
    chk("basic_busy", busy_o, 1);
    for (int c = 1; c <= LAT + 1; c++) begin
      chk("basic_early_valid", out_valid_o, 0);
      tick();
    end
    chk("basic_first_valid", out_valid_o, 1);
    wait_done("basic_timeout", 40, 4'b1111);
    exp_q = '{16'h0010, 16'h0011, 16'h0012, 16'h0018, 16'h0019, 16'h001A};
    check_stream("basic", exp_q);

    // zero rows: straight to DONE, no reads
    clear_logs();
    do_start(16'h0020, 8'd0, 8'd5, 16'h0001);
    chk("zero_done_pulse", done_o, 1);
    tick();
    chk("zero_done_clear", done_o, 0);
    tick();
    chk("zero_no_reads", addr_log.size(), 0);
    chk("zero_no_valid", vld_cnt, 0);
    chk("zero_done_once", done_cnt, 1);

    // 4x4 under 1-0-0-1 backpressure
    clear_logs();
    do_start(16'h0100, 8'd4, 8'd4, 16'h0004);
    wait_done("bp_timeout", 300, 4'b1001);
    exp_q.delete();
    for (int i = 0; i < 16; i++) exp_q.push_back(16'h0100 + 16'(i));
    check_stream("bp", exp_q);
    chk("bp_inflight_bound", (max_out <= LAT + 1) ? 32'd1 : 32'd0, 32'd1);

    // address wrap past 0xFFFF
    clear_logs();
    do_start(16'hFFFE, 8'd1, 8'd4, 16'h0000);
    wait_done("wrap_timeout", 40, 4'b1111);
    exp_q = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    check_stream("wrap", exp_q);

    // reset after 3 of 9 reads of a 3x3
    clear_logs();
    do_start(16'h0040, 8'd3, 8'd3, 16'h0010);
    for (int n = 0; n < 20 && addr_log.size() < 3; n++) tick();
    chk("rst_mid_reads_seen", addr_log.size(), 3);
    rst = 1'b0;
    #1;
    chk("rst_mid_busy", busy_o, 0);
    chk("rst_mid_rd_en", ram_rd_en_o, 0);
    chk("rst_mid_addr", ram_addr_o, 0);
    chk("rst_mid_valid", out_valid_o, 0);
    chk("rst_mid_data", out_data_o, 0);
    chk("rst_mid_last", out_last_o, 0);
    tick(); tick(); tick();
    chk("rst_mid_no_done", done_cnt, 0);
    chk("rst_mid_no_more_reads", addr_log.size(), 3);
    rst = 1'b1;
    tick();
    chk("rst_mid_stale_valid", out_valid_o, 0);
    clear_logs();
    do_start(16'h0077, 8'd1, 8'd1, 16'h0000);
    wait_done("rst_1x1_timeout", 40, 4'b1111);
    exp_q = '{16'h0077};
    check_stream("rst_1x1", exp_q);

`ifdef MATRIX_READ_COLMAJOR_EN
    // 2x2 column-major
    clear_logs();
    col_major_i = 1'b1;
    do_start(16'h0000, 8'd2, 8'd2, 16'h0010);
    col_major_i = 1'b0;
    wait_done("colmaj_timeout", 40, 4'b1111);
    exp_q = '{16'h0000, 16'h0010, 16'h0001, 16'h0011};
    check_stream("colmaj", exp_q);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
